// File: rtl/pulse_period_meter.sv
// pulse_period_meter
//   Measures the number of clk cycles between successive rising edges of an
//   asynchronous pulse/tick input. A period_valid strobe accompanies each
//   completed measurement. A sticky timeout flag is raised when no edge
//   arrives within TIMEOUT cycles.
// Ports
//   clk          : clock, all logic on posedge
//   rst_n        : asynchronous active-low reset
//   pulse_in     : asynchronous input being measured
//   clear        : synchronous clear of FSM, counter and outputs
//   period       : last measured interval, in clk cycles
//   period_valid : one-cycle strobe, period updated this cycle
//   locked       : high while the FSM is in LOCKED
//   timeout      : sticky loss-of-input flag
module pulse_period_meter #(
  parameter int CNT_WIDTH   = 32,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 100_000_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pulse_in,
  input  logic                 clear,
  output logic [CNT_WIDTH-1:0] period,
  output logic                 period_valid,
  output logic                 locked,
  output logic                 timeout
);

  localparam logic [CNT_WIDTH-1:0] TIMEOUT_C = CNT_WIDTH'(TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] ONE_C     = CNT_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, ARMED, LOCKED} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_reg;
  logic                   edge_det;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]   period_d;
  logic                   valid_d, locked_d, timeout_d;

  // Synchronizer plus edge register. The chain and edge register are not
  // affected by clear, so a level held high across a clear does not
  // produce a second edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= '0;
      edge_reg <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], pulse_in};
      edge_reg <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_det = sync_q[SYNC_STAGES-1] & ~edge_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      period       <= period_d;
      period_valid <= valid_d;
      locked       <= locked_d;
      timeout      <= timeout_d;
    end
  end

  // Priority: clear > edge > timeout check. An edge landing in the cycle
  // where cnt == TIMEOUT is a valid measurement, not a timeout.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period;
    valid_d   = 1'b0;
    timeout_d = timeout;
    if (clear) begin
      state_d   = IDLE;
      cnt_d     = '0;
      period_d  = '0;
      timeout_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (edge_det) begin
            state_d = ARMED;
            cnt_d   = ONE_C;
          end
        end
        ARMED, LOCKED: begin
          if (edge_det) begin
            state_d   = LOCKED;
            cnt_d     = ONE_C;
            period_d  = cnt_q;
            valid_d   = 1'b1;
            timeout_d = 1'b0;
          end else if (cnt_q == TIMEOUT_C) begin
            state_d   = IDLE;
            cnt_d     = '0;
            timeout_d = 1'b1;
          end else begin
            // cnt never passes TIMEOUT, so no wrap handling is needed
            cnt_d = cnt_q + ONE_C;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
    locked_d = (state_d == LOCKED);
  end

endmodule
